// File: rtl/sram_resp_pkg.sv
// Shared types and constants for the SRAM responder.
// Optional feature macro: SRAM_RESP_PRELOAD_EN (adds the INIT state and the
// boot image that is copied into the array after reset).
package sram_resp_pkg;

    localparam int DATA_W = 16;

`ifdef SRAM_RESP_PRELOAD_EN
    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_WAIT,
        ST_DRIVE
    } state_t;

    localparam int IMG_LEN   = 8;
    localparam int IMG_IDX_W = $clog2(IMG_LEN);

    localparam logic [DATA_W-1:0] PRELOAD_IMAGE [IMG_LEN] = '{
        16'hC0DE, 16'h0001, 16'h0203, 16'h0405,
        16'h0607, 16'h0809, 16'h0A0B, 16'h0C0D
    };
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DRIVE
    } state_t;
`endif

endpackage

// File: rtl/sram_resp_array.sv
// Storage array for the SRAM responder: 2^ADDR_BITS words of 16 bits,
// written on the rising edge with independent byte lanes, read
// combinationally so the responder can put data on the bus without delay.
module sram_resp_array
    import sram_resp_pkg::*;
#(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [1:0]           lane_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [DATA_W-1:0]    rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_BITS];

    // Byte-lane write: a disabled lane keeps whatever the word held before
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (lane_en[1]) begin
                mem[wr_addr][15:8] <= wr_data[15:8];
            end
            if (lane_en[0]) begin
                mem[wr_addr][7:0] <= wr_data[7:0];
            end
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sram_responder.sv
// Asynchronous-SRAM style bus responder with programmable read wait states.
// Writes complete in a single cycle; reads pass through WAIT for READ_WAIT
// cycles before the addressed word is driven onto the shared Data bus.
// Optional feature macro: SRAM_RESP_PRELOAD_EN (boot image copied in INIT).
module sram_responder
    import sram_resp_pkg::*;
#(
    parameter int ADDR_BITS = 10,
    parameter int READ_WAIT = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        CE,
    input  logic        UB,
    input  logic        LB,
    input  logic        OE,
    input  logic        WE,
    input  logic [19:0] ADDR,
    inout  wire  [15:0] Data,
    output logic        Ready,
    output logic        Err
);

    state_t             state;
    logic [2:0]         wait_cnt;
    logic [19:0]        rd_addr;
    logic               prev_active;
    logic [19:0]        prev_addr;
    logic               prev_we;

    logic               selected;
    logic               in_range;
    logic               rd_oor;
    logic               access;
    logic               err_hit;
    logic               drive_en;

    logic               ram_we;
    logic [1:0]         ram_lanes;
    logic [ADDR_BITS-1:0] ram_waddr;
    logic [DATA_W-1:0]  ram_wdata;
    logic [DATA_W-1:0]  ram_rdata;
    logic [DATA_W-1:0]  rd_word;

`ifdef SRAM_RESP_PRELOAD_EN
    logic [IMG_IDX_W-1:0] init_idx;
`endif

    assign selected = ~CE & (~UB | ~LB);
    assign in_range = (ADDR >> ADDR_BITS) == 20'd0;
    assign rd_oor   = (rd_addr >> ADDR_BITS) != 20'd0;
    assign access   = selected & (~WE | ~OE);

    // An out-of-range access flags Err only on the first cycle it appears
    assign err_hit  = access & ~in_range &
                      ~(prev_active & (prev_addr == ADDR) & (prev_we == WE));

    // Route either the bus write or the boot-image copy into the array
    always_comb begin
        ram_we    = Reset & selected & ~WE & in_range;
        ram_lanes = {~UB, ~LB};
        ram_waddr = ADDR[ADDR_BITS-1:0];
        ram_wdata = Data;
`ifdef SRAM_RESP_PRELOAD_EN
        if (state == ST_INIT) begin
            ram_we    = Reset;
            ram_lanes = 2'b11;
            ram_waddr = ADDR_BITS'(init_idx);
            ram_wdata = PRELOAD_IMAGE[init_idx];
        end
`endif
    end

    sram_resp_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk     (Clk),
        .wr_en   (ram_we),
        .lane_en (ram_lanes),
        .wr_addr (ram_waddr),
        .wr_data (ram_wdata),
        .rd_addr (rd_addr[ADDR_BITS-1:0]),
        .rd_data (ram_rdata)
    );

    // Out-of-range reads still complete their timing but return zero
    assign rd_word  = rd_oor ? '0 : ram_rdata;
    assign drive_en = (state == ST_DRIVE) & selected & ~OE & WE;

    assign Data[15:8] = (drive_en & ~UB) ? rd_word[15:8] : 8'hzz;
    assign Data[7:0]  = (drive_en & ~LB) ? rd_word[7:0]  : 8'hzz;

    // Access sequencer: write/read handshake, wait counter, Ready and Err
    always_ff @(posedge Clk) begin
        if (!Reset) begin
`ifdef SRAM_RESP_PRELOAD_EN
            state    <= ST_INIT;
            init_idx <= '0;
`else
            state    <= ST_IDLE;
`endif
            wait_cnt    <= '0;
            rd_addr     <= '0;
            prev_active <= 1'b0;
            prev_addr   <= '0;
            prev_we     <= 1'b1;
            Ready       <= 1'b0;
            Err         <= 1'b0;
        end else begin
`ifdef SRAM_RESP_PRELOAD_EN
            if (state == ST_INIT) begin
                Err         <= 1'b0;
                prev_active <= 1'b0;
                init_idx    <= init_idx + IMG_IDX_W'(1);
                if (init_idx == IMG_IDX_W'(IMG_LEN - 1)) begin
                    state <= ST_IDLE;
                    Ready <= 1'b1;
                end
            end else
`endif
            begin
                Err         <= err_hit;
                prev_active <= access;
                prev_addr   <= ADDR;
                prev_we     <= WE;
                if (!selected || !WE || OE) begin
                    state    <= ST_IDLE;
                    wait_cnt <= '0;
                    Ready    <= 1'b1;
                end else if (state == ST_IDLE || ADDR != rd_addr) begin
                    rd_addr <= ADDR;
                    if (READ_WAIT == 0) begin
                        state    <= ST_DRIVE;
                        wait_cnt <= '0;
                        Ready    <= 1'b1;
                    end else begin
                        state    <= ST_WAIT;
                        wait_cnt <= 3'(READ_WAIT);
                        Ready    <= 1'b0;
                    end
                end else if (state == ST_WAIT) begin
                    if (wait_cnt <= 3'd1) begin
                        state    <= ST_DRIVE;
                        wait_cnt <= '0;
                        Ready    <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end else begin
                    state <= ST_DRIVE;
                    Ready <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_responder.sv
// Directed plus randomized bench for sram_responder. A word-array model
// with lane masks predicts read data; released bus lanes read back as
// all-ones through a pullup. Exercises SRAM_RESP_PRELOAD_EN when defined.
module tb_sram_responder;
    import sram_resp_pkg::*;

    localparam int AB    = 10;
    localparam int RW    = 1;
    localparam int DEPTH = 1 << AB;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        CE, UB, LB, OE, WE;
    logic [19:0] ADDR;
    wire  [15:0] Data;
    logic        Ready, Err;

    logic        tb_drive;
    logic [15:0] tb_wdata;

    int compared   = 0;
    int mismatched = 0;

    logic [15:0] model_mem [DEPTH];

    assign Data = tb_drive ? tb_wdata : 16'hzzzz;
    pullup (Data);

    // Free-running 100 MHz clock
    always #5 Clk = ~Clk;

    sram_responder #(
        .ADDR_BITS (AB),
        .READ_WAIT (RW)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .CE    (CE),
        .UB    (UB),
        .LB    (LB),
        .OE    (OE),
        .WE    (WE),
        .ADDR  (ADDR),
        .Data  (Data),
        .Ready (Ready),
        .Err   (Err)
    );

    // Hard stop in case the sequence ever stalls
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ce, input logic ub, input logic lb,
                                 input logic oe, input logic we, input logic [19:0] addr,
                                 input logic drv, input logic [15:0] wdata);
        CE       = ce;
        UB       = ub;
        LB       = lb;
        OE       = oe;
        WE       = we;
        ADDR     = addr;
        tb_drive = drv;
        tb_wdata = wdata;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic busIdle();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 20'h0, 1'b0, 16'h0);
    endtask

    function automatic logic isOor(input logic [19:0] a);
        return a >= 20'(DEPTH);
    endfunction

    function automatic logic [15:0] expRead(input logic [19:0] a, input logic ub_n,
                                            input logic lb_n);
        logic [15:0] w;
        w = isOor(a) ? 16'h0000 : model_mem[a[AB-1:0]];
        return {ub_n ? 8'hFF : w[15:8], lb_n ? 8'hFF : w[7:0]};
    endfunction

    task automatic modelWrite(input logic [19:0] a, input logic [15:0] d,
                              input logic ub_n, input logic lb_n);
        logic [15:0] mask;
        mask = {{8{~ub_n}}, {8{~lb_n}}};
        if (!isOor(a)) begin
            model_mem[a[AB-1:0]] = (model_mem[a[AB-1:0]] & ~mask) | (d & mask);
        end
    endtask

    task automatic doWrite(input logic [19:0] a, input logic [15:0] d,
                           input logic ub_n, input logic lb_n);
        applyStimulus(1'b0, ub_n, lb_n, 1'b1, 1'b0, a, 1'b1, d);
        tick();
        checkOutput($sformatf("wr_err@%h", a), {15'b0, Err}, {15'b0, isOor(a)});
        checkOutput($sformatf("wr_ready@%h", a), {15'b0, Ready}, 16'h0001);
        modelWrite(a, d, ub_n, lb_n);
        busIdle();
        tick();
    endtask

    task automatic doRead(input logic [19:0] a, input logic ub_n, input logic lb_n);
        logic [15:0] exp;
        exp = expRead(a, ub_n, lb_n);
        applyStimulus(1'b0, ub_n, lb_n, 1'b0, 1'b1, a, 1'b0, 16'h0);
        tick();
        checkOutput($sformatf("rd_err@%h", a), {15'b0, Err}, {15'b0, isOor(a)});
        for (int i = 0; i < RW; i++) begin
            checkOutput($sformatf("rd_wait_ready@%h", a), {15'b0, Ready}, 16'h0000);
            checkOutput($sformatf("rd_wait_bus@%h", a), Data, 16'hFFFF);
            tick();
        end
        checkOutput($sformatf("rd_ready@%h", a), {15'b0, Ready}, 16'h0001);
        checkOutput($sformatf("rd_data@%h", a), Data, exp);
        tick();
        checkOutput($sformatf("rd_hold_err@%h", a), {15'b0, Err}, 16'h0000);
        checkOutput($sformatf("rd_hold_data@%h", a), Data, exp);
        busIdle();
        checkOutput($sformatf("rd_release@%h", a), Data, 16'hFFFF);
        tick();
    endtask

    task automatic releaseReset();
        Reset = 1'b1;
`ifdef SRAM_RESP_PRELOAD_EN
        for (int i = 1; i < IMG_LEN; i++) begin
            if (i == 3) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 20'h0, 1'b1, 16'hDEAD);
            end
            if (i == 4) begin
                busIdle();
            end
            tick();
            checkOutput("init_ready", {15'b0, Ready}, 16'h0000);
            checkOutput("init_err", {15'b0, Err}, 16'h0000);
        end
        tick();
        checkOutput("init_done_ready", {15'b0, Ready}, 16'h0001);
        for (int i = 0; i < IMG_LEN; i++) begin
            model_mem[i] = PRELOAD_IMAGE[i];
        end
`else
        tick();
        checkOutput("post_reset_ready", {15'b0, Ready}, 16'h0001);
`endif
    endtask

    // Linear directed sequence followed by a randomized phase
    initial begin
        logic [19:0] a;
        logic [15:0] d;
        logic [1:0]  lanes;
        logic        oor;

        Reset = 1'b0;
        busIdle();
        tick();
        tick();
        checkOutput("reset_ready", {15'b0, Ready}, 16'h0000);
        checkOutput("reset_err", {15'b0, Err}, 16'h0000);
        checkOutput("reset_bus", Data, 16'hFFFF);
        releaseReset();

`ifdef SRAM_RESP_PRELOAD_EN
        $display("[TB] preload image check");
        doRead(20'h0, 1'b0, 1'b0);
`endif

        $display("[TB] basic write/read");
        doWrite(20'h00005, 16'h1234, 1'b0, 1'b0);
        doRead(20'h00005, 1'b0, 1'b0);

        $display("[TB] upper-lane write");
        doWrite(20'h00007, 16'h5A3C, 1'b0, 1'b0);
        doWrite(20'h00007, 16'hABCD, 1'b0, 1'b1);
        doRead(20'h00007, 1'b0, 1'b0);
        doRead(20'h00007, 1'b1, 1'b0);
        doRead(20'h00007, 1'b0, 1'b1);

        $display("[TB] out-of-range access");
        doWrite(20'h00000, 16'h1111, 1'b0, 1'b0);
        doRead(20'h00400, 1'b0, 1'b0);
        doWrite(20'h00400, 16'hBEEF, 1'b0, 1'b0);
        doRead(20'h00000, 1'b0, 1'b0);

        $display("[TB] address change during drive");
        doWrite(20'h00006, 16'h6666, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 20'h00005, 1'b0, 16'h0);
        tick();
        for (int i = 0; i < RW; i++) begin
            tick();
        end
        checkOutput("chg_first", Data, expRead(20'h00005, 1'b0, 1'b0));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 20'h00006, 1'b0, 16'h0);
        tick();
        for (int i = 0; i < RW; i++) begin
            checkOutput("chg_wait_ready", {15'b0, Ready}, 16'h0000);
            tick();
        end
        checkOutput("chg_ready", {15'b0, Ready}, 16'h0001);
        checkOutput("chg_data", Data, expRead(20'h00006, 1'b0, 1'b0));
        busIdle();
        tick();

        $display("[TB] write abandons pending read");
        doWrite(20'h00009, 16'h0909, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 20'h00009, 1'b0, 16'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'h00009, 1'b1, 16'h7E57);
        tick();
        checkOutput("wr_abandon_ready", {15'b0, Ready}, 16'h0001);
        modelWrite(20'h00009, 16'h7E57, 1'b0, 1'b0);
        busIdle();
        tick();
        doRead(20'h00009, 1'b0, 1'b0);

        $display("[TB] no-access cycles");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 20'h00005, 1'b1, 16'hFACE);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 20'h00005, 1'b1, 16'hFACE);
        tick();
        busIdle();
        tick();
        doRead(20'h00005, 1'b0, 1'b0);

        $display("[TB] reset during wait");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 20'h00005, 1'b0, 16'h0);
        tick();
        Reset = 1'b0;
        tick();
        checkOutput("rst_wait_bus", Data, 16'hFFFF);
        checkOutput("rst_wait_ready", {15'b0, Ready}, 16'h0000);
        checkOutput("rst_wait_err", {15'b0, Err}, 16'h0000);
        busIdle();
        releaseReset();
        doRead(20'h00005, 1'b0, 1'b0);
        doRead(20'h00007, 1'b0, 1'b0);

        $display("[TB] randomized phase");
        for (int i = 0; i < 32; i++) begin
            doWrite(20'(i), 16'($urandom), 1'b0, 1'b0);
        end
        for (int n = 0; n < 40; n++) begin
            oor   = ($urandom_range(0, 7) == 0);
            a     = oor ? 20'(DEPTH + $urandom_range(0, 255)) : 20'($urandom_range(0, 31));
            d     = 16'($urandom);
            lanes = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 0) begin
                doWrite(a, d, ~lanes[1], ~lanes[0]);
            end else begin
                doRead(a, ~lanes[1], ~lanes[0]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 Parameter ADDR_BITS, default 10: implemented word-address width; memory depth is 2^ADDR_BITS x 16.
REQ-002 Parameter READ_WAIT, default 1: wait cycles inserted before read data is driven, range 0..7.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-low reset.
REQ-005 CE  input  1  active-low chip enable.
REQ-006 UB  input  1  active-low upper-byte lane enable, bits [15:8].
REQ-007 LB  input  1  active-low lower-byte lane enable, bits [7:0].
REQ-008 OE  input  1  active-low output enable (read request).
REQ-009 WE  input  1  active-low write enable.
REQ-010 ADDR  input  20  word address from the initiator.
REQ-011 Data  inout  16  shared data bus; driven only as stated in REQ-018, otherwise high-Z.
REQ-012 Ready  output  1  high when the responder can accept or is completing an access.
REQ-013 Err  output  1  one-cycle pulse on an out-of-range access.

Function
REQ-014 Selected = ~CE & (~UB | ~LB); in range = ADDR[19:ADDR_BITS] all zero.
REQ-015 States: INIT, IDLE, WAIT, DRIVE; INIT exists only per REQ-025.
REQ-016 Write: when selected, in range and ~WE at a rising edge, each enabled lane of Data is stored at ADDR[ADDR_BITS-1:0]; disabled lanes keep old contents; the state goes to IDLE; single-cycle, no wait.
REQ-017 Read: in IDLE with selected & ~OE & WE, the state goes to WAIT and the wait counter loads READ_WAIT; WAIT decrements each cycle and goes to DRIVE when it reaches zero; READ_WAIT=0 goes from IDLE directly to DRIVE on the next edge.
REQ-018 Data is driven only in DRIVE while selected & ~OE & WE holds (combinational): enabled lanes carry stored data; disabled lanes are high-Z.
REQ-019 In WAIT or DRIVE: an ADDR change restarts WAIT with the new address; deasserting CE or OE returns to IDLE and releases Data in the same cycle.
REQ-020 WE has priority over OE; if WE falls during WAIT or DRIVE, the write is performed (REQ-016) and the read is abandoned.
REQ-021 Ready is low in INIT and WAIT and high in IDLE and DRIVE.
REQ-022 Out-of-range access: a write is ignored; a read completes its timing but drives 16'h0000 on enabled lanes; Err pulses for one cycle on the edge the access is first seen.
REQ-023 CE high, or both UB and LB high, is no access: there are no writes, Data stays high-Z, and the state goes to IDLE.

Reset
REQ-024 While Reset=0 at an edge: the state goes to INIT (with the macro) or IDLE (without it), the wait counter goes to 0, Ready=0 for that cycle, Err=0, and Data is released next cycle; a mid-access read is aborted; memory is not cleared.

Configuration
REQ-025 Macro SRAM_RESP_PRELOAD_EN defined: after reset the block sits in INIT and writes PRELOAD_IMAGE words 0..IMG_LEN-1 to addresses 0..IMG_LEN-1, one word per cycle; all bus accesses in INIT are ignored (no writes, no drive, no Err); it then goes to IDLE. Macro undefined: INIT and the image are not compiled, IDLE follows reset, and contents are unknown until written.

Structure
REQ-026 Package sram_resp_pkg holds the state enum, IMG_LEN and the PRELOAD_IMAGE constant array of 16-bit words.
REQ-027 Sub-module sram_resp_array: a synchronous-write, byte-lane-enabled 2^ADDR_BITS x 16 RAM with asynchronous read; the FSM, counter, tristate and preload sequencer stay in sram_responder.

Verification
REQ-028 Write 16'h1234 to 0x00005 with both lanes, then read with READ_WAIT=1 -> Ready low for 1 cycle, then Data=16'h1234 in DRIVE.
REQ-029 Write 16'hABCD to 0x00007 with only UB, then read with both lanes -> Data=16'hAB<old low byte>; read with only LB -> Data[15:8] high-Z.
REQ-030 Read 0x00400 with ADDR_BITS=10 -> Err high for one cycle, Data=16'h0000, memory unchanged.
REQ-031 Change ADDR from 0x00005 to 0x00006 during DRIVE -> Ready low for READ_WAIT cycles, then Data is the word at 0x00006.
REQ-032 Assert Reset=0 during WAIT -> Data high-Z, Ready=0, Err=0; after release the block goes to IDLE (or INIT) with memory intact.
REQ-033 With SRAM_RESP_PRELOAD_EN -> Ready low for IMG_LEN cycles after reset; a write attempted during INIT is ignored; reading address 0 then returns PRELOAD_IMAGE[0].
